// File: rtl/array_1rw_masked_init_ext_if.sv
// Request/response bundle for the 1RW masked array; master drives requests, slave is the array.
interface array_1rw_masked_init_ext_if #(
  parameter int ADDR_W = 12,
  parameter int WIDTH  = 64,
  parameter int MASK_W = 8
);
  logic [ADDR_W-1:0] RW0_addr;
  logic              RW0_en;
  logic              RW0_wmode;
  logic [MASK_W-1:0] RW0_wmask;
  logic [WIDTH-1:0]  RW0_wdata;
  logic [WIDTH-1:0]  RW0_rdata;
  logic              RW0_rvalid;
  logic              RW0_ready;
  logic              RW0_drop;

  modport master (
    output RW0_addr, RW0_en, RW0_wmode, RW0_wmask, RW0_wdata,
    input  RW0_rdata, RW0_rvalid, RW0_ready, RW0_drop
  );

  modport slave (
    input  RW0_addr, RW0_en, RW0_wmode, RW0_wmask, RW0_wdata,
    output RW0_rdata, RW0_rvalid, RW0_ready, RW0_drop
  );
endinterface

// File: rtl/array_1rw_masked_init_ext.sv
// Single-port synchronous memory with per-lane write mask, held read data,
// read-valid strobe and a post-reset clear sequencer writing INIT_VAL to every entry.
module array_1rw_masked_init_ext #(
  parameter int                      DEPTH     = 4096,
  parameter int                      WIDTH     = 64,
  parameter int                      MASK_GRAN = 8,
  parameter logic [WIDTH-1:0]        INIT_VAL  = '0,
  parameter int                      ADDR_W    = $clog2(DEPTH),
  parameter int                      MASK_W    = WIDTH / MASK_GRAN
) (
  input  logic                                RW0_clk,
  input  logic                                RW0_rst,
  array_1rw_masked_init_ext_if.slave          rw0
);

  typedef enum logic {S_CLEAR, S_READY} state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ADDR_W-1:0] r_ptr;
  logic              r_ready;
  logic [WIDTH-1:0]  r_rdata;
  logic              r_rvalid;
  logic              r_drop;
  logic [WIDTH-1:0]  r_mem [DEPTH];

  logic              w_addr_ok;
  logic              w_clear_we;
  logic              w_wr;
  logic              w_rd;

  // Only non-power-of-2 depths can present an address past the last entry.
  generate
    if (DEPTH == (1 << ADDR_W)) begin : g_full_range
      always_comb w_addr_ok = 1'b1;
    end else begin : g_partial_range
      always_comb w_addr_ok = (rw0.RW0_addr < ADDR_W'(DEPTH));
    end
  endgenerate

  always_ff @(posedge RW0_clk) begin
    if (RW0_rst) begin
      r_state <= S_CLEAR;
      r_ptr   <= '0;
      r_ready <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_ready <= (w_state_nxt == S_READY);
      if (r_state == S_CLEAR) r_ptr <= r_ptr + ADDR_W'(1);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_clear_we  = 1'b0;
    w_wr        = 1'b0;
    w_rd        = 1'b0;
    case (r_state)
      S_CLEAR: begin
        w_clear_we = 1'b1;
        if (r_ptr == ADDR_W'(DEPTH - 1)) w_state_nxt = S_READY;
      end
      S_READY: begin
        w_wr = rw0.RW0_en & rw0.RW0_wmode & w_addr_ok;
        w_rd = rw0.RW0_en & ~rw0.RW0_wmode;
      end
      default: w_state_nxt = S_CLEAR;
    endcase
  end

  // Storage has no reset: the clear sequencer initialises it over DEPTH cycles.
  always_ff @(posedge RW0_clk) begin
    if (!RW0_rst) begin
      if (w_clear_we) begin
        r_mem[r_ptr] <= INIT_VAL;
      end else if (w_wr) begin
        for (int unsigned i = 0; i < MASK_W; i++) begin
          if (rw0.RW0_wmask[i])
            r_mem[rw0.RW0_addr][i*MASK_GRAN +: MASK_GRAN] <= rw0.RW0_wdata[i*MASK_GRAN +: MASK_GRAN];
        end
      end
    end
  end

  always_ff @(posedge RW0_clk) begin
    if (RW0_rst) begin
      r_rdata  <= '0;
      r_rvalid <= 1'b0;
      r_drop   <= 1'b0;
    end else if (r_state == S_CLEAR) begin
      if (rw0.RW0_en) r_drop <= 1'b1;
    end else begin
      r_rvalid <= w_rd;
      if (w_rd) r_rdata <= w_addr_ok ? r_mem[rw0.RW0_addr] : INIT_VAL;
    end
  end

  always_comb begin
    rw0.RW0_rdata  = r_rdata;
    rw0.RW0_rvalid = r_rvalid;
    rw0.RW0_ready  = r_ready;
    rw0.RW0_drop   = r_drop;
  end

endmodule
